z80_bus_bridge: RTL and testbench
=================================

Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 SHALL have parameter AW, default 16, CPU address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter MEM_WS, default 0, minimum memory wait cycles.
REQ-004 SHALL have parameter IO_WS, default 1, minimum I/O and INTA wait cycles.
REQ-005 SHALL have parameter TMO, default 255, max cycles a REQ may stay unacknowledged.
REQ-006 SHALL have port CLK, in, 1, the single clock; all logic SHALL be clocked by CLK rising edge.
REQ-007 SHALL have port RESET, in, 1, synchronous, active-high reset.
REQ-008 SHALL have ports nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, each in, 1, active-low CPU strobes already synchronous to CLK.
REQ-009 SHALL have ports A (in, AW, CPU address), DO (in, DW, CPU write data) and DI (out, DW, read data to CPU).
REQ-010 SHALL have port nWAIT, out, 1, active-low wait to CPU.
REQ-011 SHALL have ports req, we, io, inta (out, 1 each), addr (out, AW), wdata (out, DW), rdata (in, DW), ack (in, 1) for the target side.
REQ-012 SHALL have port err, out, 1, one-cycle timeout pulse.

Function
REQ-013 FSM states SHALL be IDLE, WS, REQ and HOLD.
REQ-014 In IDLE, a cycle SHALL start on the first CLK with one of these conditions:
  - mem: nMREQ=0, nRFSH=1, and (nRD=0 or nWR=0);
  - io: nIORQ=0, nM1=1, and (nRD=0 or nWR=0);
  - inta: nIORQ=0 and nM1=0.
REQ-015 Refresh cycles (nRFSH=0) SHALL never start a cycle.
REQ-016 On start, addr, we (=~nWR), io, inta and wdata SHALL be latched, and nWAIT SHALL go 0 in the same cycle (combinational from the start condition).
REQ-017 Entering WS, a counter SHALL load MEM_WS (mem) or IO_WS (io/inta); it SHALL skip straight to REQ when the loaded value is 0.
REQ-018 WS SHALL decrement each cycle and go to REQ when the count reaches 0.
REQ-019 In REQ, req SHALL be 1; when ack=1, rdata SHALL latch into DI, req SHALL drop next cycle, and the FSM SHALL go to HOLD.
REQ-020 Latency from start to req SHALL be exactly WS+1 cycles.
REQ-021 In HOLD, nWAIT SHALL be 1, DI SHALL be held, and the FSM SHALL return to IDLE once all of nMREQ, nIORQ, nRD and nWR are 1.
REQ-022 HOLD SHALL require strobe release before a new start, so back-to-back cycles need one idle-strobe sample.
REQ-023 A REQ cycle counter SHALL count to TMO; at TMO without ack, the block SHALL:
  - set DI to all ones;
  - pulse err for 1 cycle;
  - drop req;
  - go to HOLD.
REQ-024 ack and timeout in the same cycle SHALL be treated as ack; err SHALL stay 0.
REQ-025 ack outside REQ SHALL be ignored.
REQ-026 If the strobes deassert before ack (CPU abort), the FSM SHALL still complete the handshake, then return to IDLE.
REQ-027 Counters SHALL be sized $clog2(max+1) and SHALL NOT wrap.

Reset
REQ-028 RESET SHALL force IDLE and set req=0, nWAIT=1, err=0, DI=0, addr=0, wdata=0, we=0, io=0, inta=0 and counters to 0.
REQ-029 RESET during any state SHALL abort immediately with no err pulse.

Structure
REQ-030 The state enum and the cycle-kind constants (MEM, IO, INTA) SHALL live in shared package z80_bus_pkg.
REQ-031 Wait and timeout counting SHALL be one sub-module, z80_bus_wscnt (load, dec, zero flag), instantiated twice.

Verification
REQ-032 MEM_WS=0, mem read A=16'h1234, ack on 2nd req cycle with rdata=8'hA5 -> req 1 cycle after start, DI=8'hA5, nWAIT high after ack.
REQ-033 IO_WS=3, io write A=16'h00FE, DO=8'h3C -> req 4 cycles after start, we=1, io=1, wdata=8'h3C.
REQ-034 INTA cycle (nM1=0, nIORQ=0), rdata=8'hFF on ack -> inta=1, DI=8'hFF.
REQ-035 TMO=8, ack never -> err pulse 8 cycles after req rises, DI=8'hFF, nWAIT=1.
REQ-036 nMREQ=0 with nRFSH=0 -> req stays 0 and nWAIT stays 1.
REQ-037 RESET asserted in REQ, then ack 1 cycle later -> IDLE, req=0, ack ignored, err=0.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus bridge: FSM states, cycle kinds and counter sizing.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWs,
    StReq,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    KindMem,
    KindIo,
    KindInta
  } kind_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/z80_bus_wscnt.sv
// Saturating down-counter with load, used for both wait-state and timeout counting.
module z80_bus_wscnt import z80_bus_pkg::*; #(
  parameter int unsigned Max = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     dec_i,
  input  logic [cnt_w(Max)-1:0]    load_val_i,
  output logic                     zero_o,
  output logic                     one_o
);

  localparam int unsigned Width = cnt_w(Max);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == Width'(1));

endmodule

// File: rtl/z80_bus_bridge.sv
// Bridges Z80 CPU strobes to a req/ack target handshake with wait-state insertion and
// a request timeout that returns all-ones data and pulses err.
module z80_bus_bridge import z80_bus_pkg::*; #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned MEM_WS = 0,
  parameter int unsigned IO_WS  = 1,
  parameter int unsigned TMO    = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          nM1,
  input  logic          nMREQ,
  input  logic          nIORQ,
  input  logic          nRD,
  input  logic          nWR,
  input  logic          nRFSH,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] DO,
  output logic [DW-1:0] DI,
  output logic          nWAIT,
  output logic          req,
  output logic          we,
  output logic          io,
  output logic          inta,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          ack,
  output logic          err
);

  localparam int unsigned WsMax = (MEM_WS > IO_WS) ? MEM_WS : IO_WS;
  localparam int unsigned WsW   = cnt_w(WsMax);
  localparam int unsigned TmoW  = cnt_w(TMO);

  state_e        state_d, state_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] wdata_d, wdata_q;
  logic [DW-1:0] di_d, di_q;
  logic          we_d, we_q;
  logic          io_d, io_q;
  logic          inta_d, inta_q;
  logic          err_d, err_q;

  logic          is_mem, is_io, is_inta, start;
  kind_e         start_kind;
  logic [WsW-1:0] ws_load_val;
  logic          ws_load, ws_dec, ws_zero, ws_one;
  logic          tmo_load, tmo_dec, tmo_zero, tmo_one;

  assign is_mem  = !nMREQ && nRFSH && (!nRD || !nWR);
  assign is_io   = !nIORQ && nM1 && (!nRD || !nWR);
  assign is_inta = !nIORQ && !nM1;
  // Gated by RESET so the CPU never sees a wait while the bridge is held in reset.
  assign start   = !RESET && (state_q == StIdle) && (is_mem || is_io || is_inta);

  always_comb begin
    start_kind = KindMem;
    if (is_io) begin
      start_kind = KindIo;
    end
    if (is_inta) begin
      start_kind = KindInta;
    end
  end

  assign ws_load_val = (start_kind == KindMem) ? WsW'(MEM_WS) : WsW'(IO_WS);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    io_d     = io_q;
    inta_d   = inta_q;
    di_d     = di_q;
    err_d    = 1'b0;
    ws_load  = 1'b0;
    ws_dec   = 1'b0;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = A;
          wdata_d  = DO;
          we_d     = !nWR;
          io_d     = (start_kind == KindIo);
          inta_d   = (start_kind == KindInta);
          ws_load  = 1'b1;
          tmo_load = 1'b1;
          state_d  = (ws_load_val == '0) ? StReq : StWs;
        end
      end
      StWs: begin
        ws_dec = 1'b1;
        if (ws_one || ws_zero) begin
          state_d = StReq;
        end
      end
      StReq: begin
        tmo_dec = 1'b1;
        // ack wins over a timeout landing in the same cycle.
        if (ack) begin
          di_d    = rdata;
          state_d = StHold;
        end else if (tmo_one || tmo_zero) begin
          di_d    = '1;
          err_d   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (nMREQ && nIORQ && nRD && nWR) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      inta_q  <= 1'b0;
      di_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      io_q    <= io_d;
      inta_q  <= inta_d;
      di_q    <= di_d;
      err_q   <= err_d;
    end
  end

  z80_bus_wscnt #(
    .Max (WsMax)
  ) u_ws_cnt (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (ws_load),
    .dec_i      (ws_dec),
    .load_val_i (ws_load_val),
    .zero_o     (ws_zero),
    .one_o      (ws_one)
  );

  z80_bus_wscnt #(
    .Max (TMO)
  ) u_tmo_cnt (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (tmo_load),
    .dec_i      (tmo_dec),
    .load_val_i (TmoW'(TMO)),
    .zero_o     (tmo_zero),
    .one_o      (tmo_one)
  );

  assign req   = (state_q == StReq);
  assign nWAIT = !(start || (state_q == StWs) || (state_q == StReq));
  assign DI    = di_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign we    = we_q;
  assign io    = io_q;
  assign inta  = inta_q;
  assign err   = err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Self-checking bench for z80_bus_bridge: directed vector table, reset/refresh corners,
// and random transactions checked against a transaction-level timeline model.
module tb_z80_bus_bridge;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 8;
  localparam int unsigned MEM_WS = 0;
  localparam int unsigned IO_WS  = 3;
  localparam int unsigned TMO    = 8;

  localparam int KMemRd = 0;
  localparam int KMemWr = 1;
  localparam int KIoRd  = 2;
  localparam int KIoWr  = 3;
  localparam int KInta  = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [AW-1:0] A;
  logic [DW-1:0] DO, DI, rdata, wdata;
  logic [AW-1:0] addr;
  logic          nWAIT, req, we, io, inta, ack, err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int            kind;
    logic [15:0]   a;
    logic [7:0]    dout;
    logic [7:0]    rdin;
    int            ack_delay;
    bit            noise;
    bit            abort;
    int            exp_lat;
    logic [7:0]    exp_di;
    bit            exp_err;
  } vec_t;

  z80_bus_bridge #(
    .AW     (AW),
    .DW     (DW),
    .MEM_WS (MEM_WS),
    .IO_WS  (IO_WS),
    .TMO    (TMO)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .nM1   (nM1),
    .nMREQ (nMREQ),
    .nIORQ (nIORQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .nRFSH (nRFSH),
    .A     (A),
    .DO    (DO),
    .DI    (DI),
    .nWAIT (nWAIT),
    .req   (req),
    .we    (we),
    .io    (io),
    .inta  (inta),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_strobes(input int kind, input bit on);
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    if (on) begin
      case (kind)
        KMemRd: begin nMREQ = 1'b0; nRD = 1'b0; end
        KMemWr: begin nMREQ = 1'b0; nWR = 1'b0; end
        KIoRd:  begin nIORQ = 1'b0; nRD = 1'b0; end
        KIoWr:  begin nIORQ = 1'b0; nWR = 1'b0; end
        default: begin nM1 = 1'b0; nIORQ = 1'b0; end
      endcase
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Drives one CPU cycle and checks every output cycle by cycle against the timeline:
  // req high from exp_lat for ack_delay+1 cycles (or TMO cycles on timeout), then HOLD.
  task automatic run_txn(input string name, input vec_t v);
    int last;
    int ack_c;
    bit exp_we, exp_io, exp_inta;
    exp_we   = (v.kind == KMemWr) || (v.kind == KIoWr);
    exp_io   = (v.kind == KIoRd) || (v.kind == KIoWr);
    exp_inta = (v.kind == KInta);
    last  = v.exp_lat + (v.exp_err ? int'(TMO) - 1 : v.ack_delay);
    ack_c = v.exp_lat + v.ack_delay;
    set_strobes(v.kind, 1'b1);
    A  = v.a;
    DO = v.dout;
    for (int c = 0; c <= last + 2; c++) begin
      if (c > 0) begin
        A  = AW'($urandom);
        DO = DW'($urandom);
      end
      if (v.abort && c == 1) set_strobes(v.kind, 1'b0);
      ack   = (c == ack_c) || (v.noise && c < v.exp_lat && $urandom_range(0, 1) == 1);
      rdata = (c == ack_c) ? v.rdin : DW'($urandom);
      @(negedge CLK);
      check({name, ".req"}, req, (c >= v.exp_lat) && (c <= last));
      check({name, ".nwait"}, nWAIT, c > last);
      check({name, ".err"}, err, (c == last + 1) && v.exp_err);
      if (c == v.exp_lat) begin
        check({name, ".addr"}, addr, v.a);
        check({name, ".wdata"}, wdata, v.dout);
        check({name, ".we"}, we, exp_we);
        check({name, ".io"}, io, exp_io);
        check({name, ".inta"}, inta, exp_inta);
      end
      if (c > last) check({name, ".di"}, DI, v.exp_di);
      next_cycle();
    end
    set_strobes(v.kind, 1'b0);
    ack = 1'b0;
    @(negedge CLK);
    check({name, ".rel_req"}, req, 1'b0);
    check({name, ".rel_nwait"}, nWAIT, 1'b1);
    next_cycle();
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    // {kind, A, DO, rdata, ack_delay, noise, abort, exp_lat, exp_di, exp_err}
    vecs[0] = '{KMemRd, 16'h1234, 8'h00, 8'hA5, 1,  1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[1] = '{KIoWr,  16'h00FE, 8'h3C, 8'h5A, 0,  1'b1, 1'b0, 4, 8'h5A, 1'b0};
    vecs[2] = '{KInta,  16'h0038, 8'h11, 8'hFF, 2,  1'b1, 1'b0, 4, 8'hFF, 1'b0};
    vecs[3] = '{KMemRd, 16'h2000, 8'h22, 8'h33, 99, 1'b0, 1'b0, 1, 8'hFF, 1'b1};
    vecs[4] = '{KMemWr, 16'h8000, 8'h77, 8'h42, 7,  1'b0, 1'b0, 1, 8'h42, 1'b0};
    vecs[5] = '{KIoRd,  16'h0010, 8'h44, 8'hC3, 8,  1'b1, 1'b0, 4, 8'hFF, 1'b1};
    vecs[6] = '{KMemRd, 16'h4321, 8'h55, 8'h99, 3,  1'b0, 1'b1, 1, 8'h99, 1'b0};

    // Reset with an active memory read on the bus: nothing may start.
    RESET = 1'b1;
    set_strobes(KMemRd, 1'b1);
    A = 16'hFFFF; DO = 8'hFF; ack = 1'b0; rdata = 8'h00;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("rst.req", req, 1'b0);
    check("rst.nwait", nWAIT, 1'b1);
    check("rst.err", err, 1'b0);
    check("rst.di", DI, 8'h00);
    check("rst.addr", addr, 16'h0000);
    check("rst.wdata", wdata, 8'h00);
    check("rst.we", we, 1'b0);
    check("rst.io", io, 1'b0);
    check("rst.inta", inta, 1'b0);
    next_cycle();
    RESET = 1'b0;
    set_strobes(KMemRd, 1'b0);
    next_cycle();

    // Refresh cycles must never start a transfer, with or without nRD.
    for (int i = 0; i < 4; i++) begin
      nMREQ = 1'b0; nRFSH = 1'b0; nRD = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge CLK);
      check("rfsh.req", req, 1'b0);
      check("rfsh.nwait", nWAIT, 1'b1);
      next_cycle();
    end
    set_strobes(KMemRd, 1'b0);
    next_cycle();
    @(negedge CLK);
    check("rfsh.after_req", req, 1'b0);
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while in REQ, then a late ack: must be ignored, no err, DI cleared.
    set_strobes(KMemRd, 1'b1);
    A = 16'hBEEF;
    @(negedge CLK);
    check("rstreq.start_nwait", nWAIT, 1'b0);
    next_cycle();
    RESET = 1'b1;
    set_strobes(KMemRd, 1'b0);
    @(negedge CLK);
    check("rstreq.req_before", req, 1'b1);
    next_cycle();
    RESET = 1'b0;
    ack   = 1'b1;
    rdata = 8'h5A;
    @(negedge CLK);
    check("rstreq.req", req, 1'b0);
    check("rstreq.err", err, 1'b0);
    check("rstreq.nwait", nWAIT, 1'b1);
    check("rstreq.di", DI, 8'h00);
    check("rstreq.addr", addr, 16'h0000);
    next_cycle();
    ack = 1'b0;
    @(negedge CLK);
    check("rstreq.req2", req, 1'b0);
    check("rstreq.err2", err, 1'b0);
    check("rstreq.di2", DI, 8'h00);
    next_cycle();

    // Random transactions; expectations come from the cycle-kind rules alone.
    for (int i = 0; i < 40; i++) begin
      rv.kind      = int'($urandom_range(0, 4));
      rv.a         = 16'($urandom);
      rv.dout      = 8'($urandom);
      rv.rdin      = 8'($urandom);
      rv.ack_delay = int'($urandom_range(0, TMO + 2));
      rv.noise     = 1'b1;
      rv.abort     = ($urandom_range(0, 3) == 0);
      rv.exp_lat   = int'((rv.kind == KMemRd || rv.kind == KMemWr) ? MEM_WS : IO_WS) + 1;
      rv.exp_err   = (rv.ack_delay >= int'(TMO));
      rv.exp_di    = rv.exp_err ? 8'hFF : rv.rdin;
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
